sme_ctrl: RTL and testbench

SME_CTRL -- requirements
Module: sme_ctrl

---
 rtl/sme_pkg.sv | 25 ++
 rtl/sme_char_buf.sv | 34 +++
 rtl/sme_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_sme_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/sme_pkg.sv
// Shared types and constants for the regex-engine front-end controller.
// Holds the controller state encoding, default buffer depths and special characters.
package sme_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SEND_STR = 3'd1,
    SEND_PAT = 3'd2,
    GAP      = 3'd3,
    WAIT     = 3'd4,
    DONE     = 3'd5
  } sme_state_e;

  localparam int STR_DEPTH_DEF = 32;
  localparam int PAT_DEPTH_DEF = 10;
  localparam int TIMEOUT_DEF   = 1023;
  localparam int CNT_W         = 10;
  localparam int IDX_W         = 5;

  localparam logic [7:0] CH_HAT    = 8'h5E;
  localparam logic [7:0] CH_DOLLAR = 8'h24;
  localparam logic [7:0] CH_DOT    = 8'h2E;
  localparam logic [7:0] CH_SPACE  = 8'h20;

endpackage

// File: rtl/sme_char_buf.sv
// Depth x 8 character register file: one synchronous write port, one combinational read port.
// Contents are deliberately not reset; the lengths kept by the controller define what is valid.
module sme_char_buf #(
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem_r [DEPTH];

  // Write port; addresses past a non-power-of-two depth are dropped
  always_ff @(posedge clk) begin
    if (we && (int'(waddr) < DEPTH)) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Combinational read port
  always_comb begin
    rdata = 8'h00;
    if (int'(raddr) < DEPTH) begin
      rdata = mem_r[raddr];
    end else begin
      rdata = 8'h00;
    end
  end

endmodule

// File: rtl/sme_ctrl.sv
// Host-side controller: buffers a string and a pattern, streams them to the match
// engine, then waits (with timeout) for the engine result and reports it with done.
module sme_ctrl
  import sme_pkg::*;
#(
  parameter int STR_DEPTH = STR_DEPTH_DEF,
  parameter int PAT_DEPTH = PAT_DEPTH_DEF,
  parameter int TIMEOUT   = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic             wr_pat,
  input  logic [7:0]       wr_data,
  input  logic             clr,
  input  logic             start,
  input  logic             keep_str,
  output logic             busy,
  output logic             done,
  output logic             match,
  output logic [IDX_W-1:0] match_index,
  output logic             err,
  output logic [7:0]       eng_chardata,
  output logic             eng_isstring,
  output logic             eng_ispattern,
  input  logic             eng_valid,
  input  logic             eng_match,
  input  logic [IDX_W-1:0] eng_match_index
);

  localparam int SAW = $clog2(STR_DEPTH);
  localparam int PAW = $clog2(PAT_DEPTH);
  localparam int SLW = $clog2(STR_DEPTH + 1);
  localparam int PLW = $clog2(PAT_DEPTH + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  sme_state_e       state_r;
  logic [SLW-1:0]   str_len_r, sidx_r;
  logic [PLW-1:0]   pat_len_r, pidx_r;
  logic [CNT_W-1:0] cnt_r;
  logic             busy_r, done_r, match_r, err_r;
  logic [IDX_W-1:0] match_index_r;
  logic [7:0]       chardata_r;
  logic             isstring_r, ispattern_r;

  logic             str_we_s, pat_we_s, job_err_s;
  logic [7:0]       str_rd_s, pat_rd_s;

  assign busy          = busy_r;
  assign done          = done_r;
  assign match         = match_r;
  assign match_index   = match_index_r;
  assign err           = err_r;
  assign eng_chardata  = chardata_r;
  assign eng_isstring  = isstring_r;
  assign eng_ispattern = ispattern_r;

  // Host writes land only in IDLE, and start or clr take precedence over them
  always_comb begin
    str_we_s  = 1'b0;
    pat_we_s  = 1'b0;
    job_err_s = (pat_len_r == {PLW{1'b0}}) || ((str_len_r == {SLW{1'b0}}) && !keep_str);
    if ((state_r == IDLE) && wr_en && !start && !clr) begin
      str_we_s = !wr_pat && (str_len_r < SLW'(STR_DEPTH));
      pat_we_s = wr_pat && (pat_len_r < PLW'(PAT_DEPTH));
    end else begin
      str_we_s = 1'b0;
      pat_we_s = 1'b0;
    end
  end

  sme_char_buf #(.DEPTH(STR_DEPTH)) u_str_buf (
    .clk   (clk),
    .we    (str_we_s),
    .waddr (str_len_r[SAW-1:0]),
    .wdata (wr_data),
    .raddr (sidx_r[SAW-1:0]),
    .rdata (str_rd_s)
  );

  sme_char_buf #(.DEPTH(PAT_DEPTH)) u_pat_buf (
    .clk   (clk),
    .we    (pat_we_s),
    .waddr (pat_len_r[PAW-1:0]),
    .wdata (wr_data),
    .raddr (pidx_r[PAW-1:0]),
    .rdata (pat_rd_s)
  );

  // Job sequencer; the read indices run one ahead of the character on the engine bus
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= IDLE;
      str_len_r     <= {SLW{1'b0}};
      pat_len_r     <= {PLW{1'b0}};
      sidx_r        <= {SLW{1'b0}};
      pidx_r        <= {PLW{1'b0}};
      cnt_r         <= {CNT_W{1'b0}};
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      match_r       <= 1'b0;
      match_index_r <= {IDX_W{1'b0}};
      err_r         <= 1'b0;
      chardata_r    <= 8'h00;
      isstring_r    <= 1'b0;
      ispattern_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            if (job_err_s) begin
              state_r       <= DONE;
              done_r        <= 1'b1;
              err_r         <= 1'b1;
              match_r       <= 1'b0;
              match_index_r <= {IDX_W{1'b0}};
            end else if (keep_str) begin
              state_r     <= SEND_PAT;
              busy_r      <= 1'b1;
              ispattern_r <= 1'b1;
              chardata_r  <= pat_rd_s;
              pidx_r      <= PLW'(1);
            end else begin
              state_r    <= SEND_STR;
              busy_r     <= 1'b1;
              isstring_r <= 1'b1;
              chardata_r <= str_rd_s;
              sidx_r     <= SLW'(1);
            end
          end else if (clr) begin
            str_len_r <= {SLW{1'b0}};
            pat_len_r <= {PLW{1'b0}};
          end else if (str_we_s) begin
            str_len_r <= str_len_r + SLW'(1);
          end else if (pat_we_s) begin
            pat_len_r <= pat_len_r + PLW'(1);
          end
        end
        SEND_STR: begin
          if (sidx_r == str_len_r) begin
            state_r     <= SEND_PAT;
            isstring_r  <= 1'b0;
            ispattern_r <= 1'b1;
            chardata_r  <= pat_rd_s;
            pidx_r      <= PLW'(1);
          end else begin
            chardata_r <= str_rd_s;
            sidx_r     <= sidx_r + SLW'(1);
          end
        end
        SEND_PAT: begin
          if (pidx_r == pat_len_r) begin
            state_r     <= GAP;
            ispattern_r <= 1'b0;
            chardata_r  <= 8'h00;
          end else begin
            chardata_r <= pat_rd_s;
            pidx_r     <= pidx_r + PLW'(1);
          end
        end
        GAP: begin
          state_r <= WAIT;
          cnt_r   <= {CNT_W{1'b0}};
          sidx_r  <= {SLW{1'b0}};
          pidx_r  <= {PLW{1'b0}};
        end
        WAIT: begin
          if (eng_valid) begin
            state_r       <= DONE;
            done_r        <= 1'b1;
            match_r       <= eng_match;
            match_index_r <= eng_match_index;
            err_r         <= 1'b0;
          end else if (cnt_r == TIMEOUT_C) begin
            state_r       <= DONE;
            done_r        <= 1'b1;
            match_r       <= 1'b0;
            match_index_r <= {IDX_W{1'b0}};
            err_r         <= 1'b1;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        DONE: begin
          state_r <= IDLE;
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          cnt_r   <= {CNT_W{1'b0}};
        end
        default: begin
          state_r     <= IDLE;
          busy_r      <= 1'b0;
          done_r      <= 1'b0;
          isstring_r  <= 1'b0;
          ispattern_r <= 1'b0;
          chardata_r  <= 8'h00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sme_ctrl.sv
// Randomised self-checking bench for sme_ctrl against a queue-based model of the
// buffers and the expected engine traffic/result of each job.
module tb_sme_ctrl;
  import sme_pkg::*;

  localparam int TO   = 1023;
  localparam int SDEP = 32;
  localparam int PDEP = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_en = 1'b0, wr_pat = 1'b0, clr = 1'b0, start = 1'b0, keep_str = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       busy, done, match, err;
  logic [4:0] match_index;
  logic [7:0] eng_chardata;
  logic       eng_isstring, eng_ispattern;
  logic       eng_valid = 1'b0, eng_match = 1'b0;
  logic [4:0] eng_match_index = 5'd0;

  int n_cmp = 0;
  int n_bad = 0;

  byte unsigned str_q[$];
  byte unsigned pat_q[$];
  logic         last_match = 1'b0, last_err = 1'b0;
  logic [4:0]   last_idx = 5'd0;

  sme_ctrl #(.STR_DEPTH(SDEP), .PAT_DEPTH(PDEP), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_pat(wr_pat), .wr_data(wr_data),
    .clr(clr), .start(start), .keep_str(keep_str), .busy(busy), .done(done),
    .match(match), .match_index(match_index), .err(err), .eng_chardata(eng_chardata),
    .eng_isstring(eng_isstring), .eng_ispattern(eng_ispattern), .eng_valid(eng_valid),
    .eng_match(eng_match), .eng_match_index(eng_match_index)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic byte unsigned rand_ch();
    int r;
    r = $urandom_range(0, 29);
    case (r)
      26: return CH_HAT;
      27: return CH_DOLLAR;
      28: return CH_DOT;
      29: return CH_SPACE;
      default: return 8'(8'h61 + r);
    endcase
  endfunction

  task automatic host_wr(input bit p, input byte unsigned c);
    wr_en = 1'b1; wr_pat = p; wr_data = c;
    tick();
    wr_en = 1'b0;
    if (p && pat_q.size() < PDEP) pat_q.push_back(c);
    if (!p && str_q.size() < SDEP) str_q.push_back(c);
  endtask

  task automatic host_str(input bit p, input string s);
    for (int i = 0; i < s.len(); i++) host_wr(p, s[i]);
  endtask

  // clr with a random concurrent write: clear must win
  task automatic do_clr();
    clr = 1'b1; wr_en = 1'($urandom); wr_pat = 1'($urandom); wr_data = 8'($urandom);
    tick();
    clr = 1'b0; wr_en = 1'b0;
    str_q.delete(); pat_q.delete();
  endtask

  task automatic noise();
    wr_en = 1'($urandom); wr_pat = 1'($urandom); wr_data = 8'($urandom);
    clr = ($urandom_range(0, 3) == 0); start = 1'($urandom);
    eng_valid = 1'($urandom); eng_match = 1'($urandom); eng_match_index = 5'($urandom);
  endtask

  task automatic quiet();
    wr_en = 1'b0; clr = 1'b0; start = 1'b0; eng_valid = 1'b0;
  endtask

  task automatic run_job(input bit keep, input int delay, input bit no_resp,
                         input bit m, input logic [4:0] ix, input bit nz);
    logic [8:0] exp_q[$];
    bit         is_err;
    bit         early;
    int         k;
    is_err = (pat_q.size() == 0) || (str_q.size() == 0 && !keep);
    start = 1'b1; keep_str = keep;
    tick();
    start = 1'b0; keep_str = 1'b0;
    if (is_err) begin
      chk("err_done", {done, busy, err, match, match_index, eng_isstring, eng_ispattern, eng_chardata},
          {1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 8'h00});
      last_err = 1'b1; last_match = 1'b0; last_idx = 5'd0;
      tick();
      chk("err_after", {done, busy, eng_isstring, eng_ispattern}, 4'b0000);
      return;
    end
    if (!keep) foreach (str_q[i]) exp_q.push_back({1'b1, str_q[i]});
    foreach (pat_q[i]) exp_q.push_back({1'b0, pat_q[i]});
    foreach (exp_q[i]) begin
      chk("stream", {done, busy, eng_isstring, eng_ispattern, eng_chardata},
          {1'b0, 1'b1, exp_q[i][8], ~exp_q[i][8], exp_q[i][7:0]});
      if (nz) noise();
      tick();
    end
    chk("gap", {done, busy, eng_isstring, eng_ispattern, eng_chardata}, {1'b0, 1'b1, 1'b0, 1'b0, 8'h00});
    if (nz) noise();
    tick();
    quiet();
    chk("wait_in", {done, busy, eng_isstring, eng_ispattern, eng_chardata}, {1'b0, 1'b1, 1'b0, 1'b0, 8'h00});
    if (no_resp) begin
      k = 0;
      while (!done && k <= TO + 4) begin
        tick();
        k++;
      end
      chk("to_latency", k, TO + 1);
      chk("to_result", {busy, err, match, match_index}, {1'b1, 1'b1, 1'b0, 5'd0});
      last_err = 1'b1; last_match = 1'b0; last_idx = 5'd0;
    end else begin
      early = 1'b0;
      for (int d = 0; d < delay; d++) begin
        tick();
        if (done) early = 1'b1;
      end
      chk("no_early_done", early, 0);
      eng_valid = 1'b1; eng_match = m; eng_match_index = ix;
      tick();
      eng_valid = 1'b0; eng_match = ~m; eng_match_index = ~ix;
      chk("resp", {done, busy, err, match, match_index}, {1'b1, 1'b1, 1'b0, m, ix});
      last_err = 1'b0; last_match = m; last_idx = ix;
    end
    tick();
    chk("post_done", {done, busy}, 2'b00);
    eng_valid = 1'b1;
    tick();
    eng_valid = 1'b0;
    tick();
    chk("hold", {done, busy, err, match, match_index}, {1'b0, 1'b0, last_err, last_match, last_idx});
  endtask

  task automatic reset_in_wait();
    bit seen;
    int n;
    n = str_q.size() + pat_q.size() + 1;
    start = 1'b1; keep_str = 1'b0;
    tick();
    start = 1'b0;
    repeat (n + 5) tick();
    chk("mid_busy", busy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_reset", {busy, done, match, match_index, err, eng_isstring, eng_ispattern, eng_chardata}, 0);
    str_q.delete(); pat_q.delete();
    last_err = 1'b0; last_match = 1'b0; last_idx = 5'd0;
    seen = 1'b0;
    repeat (20) begin
      tick();
      if (done || busy) seen = 1'b1;
    end
    chk("mid_no_done", seen, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick();
    chk("reset_state", {busy, done, match, match_index, err, eng_isstring, eng_ispattern, eng_chardata}, 0);
    reset = 1'b0;
    tick();

    host_str(1'b0, "hello world");
    host_str(1'b1, "^wor");
    run_job(1'b0, 3, 1'b0, 1'b1, 5'd6, 1'b0);

    do_clr();
    host_str(1'b0, "hello world");
    host_str(1'b1, "o.d$");
    run_job(1'b1, 2, 1'b0, 1'b1, 5'd8, 1'b0);

    run_job(1'b0, 0, 1'b1, 1'b0, 5'd0, 1'b0);
    run_job(1'b1, TO, 1'b0, 1'b1, 5'd17, 1'b0);

    do_clr();
    run_job(1'b0, 0, 1'b0, 1'b1, 5'd1, 1'b0);
    host_wr(1'b1, CH_DOT);
    run_job(1'b0, 0, 1'b0, 1'b1, 5'd1, 1'b0);
    run_job(1'b1, 1, 1'b0, 1'b0, 5'd3, 1'b0);

    for (int i = 0; i < 33; i++) host_wr(1'b0, rand_ch());
    for (int i = 0; i < 12; i++) host_wr(1'b1, rand_ch());
    run_job(1'b0, 4, 1'b0, 1'b1, 5'd31, 1'b1);

    reset_in_wait();
    host_str(1'b0, "abc");
    host_str(1'b1, "^a");
    run_job(1'b1, 0, 1'b1, 1'b0, 5'd0, 1'b1);

    for (int j = 0; j < 25; j++) begin
      int ns, np;
      if ($urandom_range(0, 3) == 0) do_clr();
      ns = ($urandom_range(0, 9) == 0) ? 34 : $urandom_range(0, 6);
      np = ($urandom_range(0, 9) == 0) ? 12 : $urandom_range(0, 4);
      for (int i = 0; i < ns; i++) host_wr(1'b0, rand_ch());
      for (int i = 0; i < np; i++) host_wr(1'b1, rand_ch());
      run_job($urandom_range(0, 2) == 0, $urandom_range(0, 12), 1'b0,
              1'($urandom), 5'($urandom), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
